pipe_tag_ctrl: RTL and testbench

Stage-tag pipeline controller for the six-stage core: carries per-instruction destination/write-enable/load tags from Decode through Execute, Memory and Writeback with valid bits. It applies the hazard unit's stall and flush requests to those tags, inserting bubbles and squashing wrong-path instructions. It drives the stage tags the hazard unit consumes, closing the detect→act loop between hazard detection and the pipeline registers.

---
 rtl/pipe_tag_ctrl_pkg.sv | 26 ++
 rtl/pipe_tag_stage.sv | 34 +++
 rtl/pipe_tag_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_tag_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_tag_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_tag_ctrl_pkg
// Brief    : Shared stage-tag type, bubble constant and tag helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_tag_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
  } stageTag_t;

  localparam stageTag_t BUBBLE = '0;

  // Writes to r0 are architecturally discarded, so they never count as writes.
  function automatic logic tagWritesReg(input stageTag_t t);
    return t.valid & t.regwrite & (t.rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_tag_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_tag_stage
// Brief    : One stage-tag register with bubble / load / hold control.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_tag_stage
  import pipe_tag_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_load,
  input  logic      i_bubble,
  input  stageTag_t i_tag,
  output stageTag_t o_tag
);

  stageTag_t r_tag;

  // Bubble wins over load; neither asserted means the stage holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= BUBBLE;
    end else if (i_bubble) begin
      r_tag <= BUBBLE;
    end else if (i_load) begin
      r_tag <= i_tag;
    end
  end

  assign o_tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/pipe_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_tag_ctrl
// Brief    : D/X/M/W stage-tag pipeline with stall bubbles and flush squash.
//            Optional statistics counters enabled by `define PIPE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_tag_ctrl
  import pipe_tag_ctrl_pkg::stageTag_t;
  import pipe_tag_ctrl_pkg::BUBBLE;
  import pipe_tag_ctrl_pkg::tagWritesReg;
#(
  parameter int REG_AW = pipe_tag_ctrl_pkg::REG_AW
`ifdef PIPE_STATS_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [REG_AW-1:0] f_rd,
  input  logic              f_regwrite,
  input  logic              f_load,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              pc_en,
  output logic              fd_en,
  output logic [REG_AW-1:0] writeadd_x,
  output logic [REG_AW-1:0] writeadd_m,
  output logic [REG_AW-1:0] writeadd_w,
  output logic              regwrite_x,
  output logic              regwrite_m,
  output logic              regwrite_w,
  output logic              load_x,
  output logic              load_m,
  output logic              valid_d,
  output logic              valid_x,
  output logic              valid_m,
  output logic              valid_w,
  output logic              retire
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  localparam int c_STAGE_D = 0;
  localparam int c_STAGE_X = 1;
  localparam int c_STAGE_M = 2;
  localparam int c_STAGE_W = 3;

  stageTag_t  w_fetchTag;
  stageTag_t  w_stageIn  [4];
  stageTag_t  w_stageOut [4];
  logic [3:0] w_stageLoad;
  logic [3:0] w_stageBubble;
  logic       w_advance;

  // Flush overrides stall: the stalled instruction is on the wrong path.
  assign w_advance = ~stall_in | flush_in;
  assign pc_en     = w_advance;
  assign fd_en     = w_advance;

  always_comb begin
    w_fetchTag = BUBBLE;
    if (f_valid) begin
      w_fetchTag = '{valid: 1'b1, rd: f_rd, regwrite: f_regwrite, load: f_load};
    end
  end

  always_comb begin
    w_stageIn[c_STAGE_D]     = w_fetchTag;
    w_stageIn[c_STAGE_X]     = w_stageOut[c_STAGE_D];
    w_stageIn[c_STAGE_M]     = w_stageOut[c_STAGE_X];
    w_stageIn[c_STAGE_W]     = w_stageOut[c_STAGE_M];
    w_stageLoad              = 4'b1111;
    w_stageLoad[c_STAGE_D]   = w_advance;
    w_stageBubble            = 4'b0000;
    w_stageBubble[c_STAGE_D] = flush_in;
    w_stageBubble[c_STAGE_X] = stall_in | flush_in;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
      pipe_tag_stage u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_stageLoad[gi]),
        .i_bubble (w_stageBubble[gi]),
        .i_tag    (w_stageIn[gi]),
        .o_tag    (w_stageOut[gi])
      );
    end
  endgenerate

  assign valid_d    = w_stageOut[c_STAGE_D].valid;
  assign valid_x    = w_stageOut[c_STAGE_X].valid;
  assign valid_m    = w_stageOut[c_STAGE_M].valid;
  assign valid_w    = w_stageOut[c_STAGE_W].valid;

  assign writeadd_x = valid_x ? w_stageOut[c_STAGE_X].rd : '0;
  assign writeadd_m = valid_m ? w_stageOut[c_STAGE_M].rd : '0;
  assign writeadd_w = valid_w ? w_stageOut[c_STAGE_W].rd : '0;

  assign regwrite_x = tagWritesReg(w_stageOut[c_STAGE_X]);
  assign regwrite_m = tagWritesReg(w_stageOut[c_STAGE_M]);
  assign regwrite_w = tagWritesReg(w_stageOut[c_STAGE_W]);

  assign load_x     = valid_x & w_stageOut[c_STAGE_X].load;
  assign load_m     = valid_m & w_stageOut[c_STAGE_M].load;

  assign retire     = valid_w;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic [CNT_W-1:0] r_retireCnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
      r_retireCnt <= '0;
    end else begin
      if (stall_in && !flush_in && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (flush_in && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
      if (retire && (r_retireCnt != '1)) begin
        r_retireCnt <= r_retireCnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = r_stallCnt;
  assign flush_cnt  = r_flushCnt;
  assign retire_cnt = r_retireCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_tag_ctrl
// Brief    : Directed scoreboard bench for pipe_tag_ctrl (PIPE_STATS_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_tag_ctrl;

  localparam int REG_AW = 5;
`ifdef PIPE_STATS_EN
  localparam int CNT_W  = 4;
`endif

  logic              clk;
  logic              rst_n;
  logic              f_valid;
  logic [REG_AW-1:0] f_rd;
  logic              f_regwrite;
  logic              f_load;
  logic              stall_in;
  logic              flush_in;
  logic              pc_en;
  logic              fd_en;
  logic [REG_AW-1:0] writeadd_x;
  logic [REG_AW-1:0] writeadd_m;
  logic [REG_AW-1:0] writeadd_w;
  logic              regwrite_x;
  logic              regwrite_m;
  logic              regwrite_w;
  logic              load_x;
  logic              load_m;
  logic              valid_d;
  logic              valid_x;
  logic              valid_m;
  logic              valid_w;
  logic              retire;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  retire_cnt;
`endif

  pipe_tag_ctrl #(
    .REG_AW (REG_AW)
`ifdef PIPE_STATS_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_valid    (f_valid),
    .f_rd       (f_rd),
    .f_regwrite (f_regwrite),
    .f_load     (f_load),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .writeadd_x (writeadd_x),
    .writeadd_m (writeadd_m),
    .writeadd_w (writeadd_w),
    .regwrite_x (regwrite_x),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .load_x     (load_x),
    .load_m     (load_m),
    .valid_d    (valid_d),
    .valid_x    (valid_x),
    .valid_m    (valid_m),
    .valid_w    (valid_w),
    .retire     (retire)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected retirements, oldest first: {rd, exported regwrite}.
  logic [REG_AW:0] expQ[$];
  logic [REG_AW:0] monE;
  int checks   = 0;
  int failures = 0;
  int expStall = 0;
  int expFlush = 0;
  int retired  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic setIn(input logic fv, input logic [REG_AW-1:0] rd, input logic rw,
                       input logic ld, input logic st, input logic fl);
    f_valid    = fv;
    f_rd       = rd;
    f_regwrite = rw;
    f_load     = ld;
    stall_in   = st;
    flush_in   = fl;
  endtask

  task automatic idle();
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    if (rst_n && stall_in && !flush_in) expStall++;
    if (rst_n && flush_in) expFlush++;
    @(posedge clk);
    #1;
  endtask

`ifdef PIPE_STATS_EN
  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction
`endif

  // Monitor: every retirement must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && retire) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire actual_rd=%0d expected=none", writeadd_w);
      end else begin
        monE = expQ.pop_front();
        chk("retire_rd", 32'(writeadd_w), 32'(monE[REG_AW:1]));
        chk("retire_regwrite", 32'(regwrite_w), 32'(monE[0]));
        retired++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_writeadd", 32'({writeadd_x, writeadd_m, writeadd_w}), 32'd0);
    chk("rst_flags", 32'({regwrite_x, regwrite_m, regwrite_w, load_x, load_m, retire}), 32'd0);
    chk("rst_valid", 32'({valid_d, valid_x, valid_m, valid_w}), 32'd0);
    chk("rst_pc_fd_en", 32'({pc_en, fd_en}), 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Four back-to-back writers rd=1..4.
    for (int i = 1; i <= 4; i++) expQ.push_back({5'(i), 1'b1});
    setIn(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("t1_valid_d", 32'(valid_d), 32'd1);
    setIn(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("t1_writeadd_x", 32'(writeadd_x), 32'd1);
    chk("t1_regwrite_x", 32'(regwrite_x), 32'd1);
    setIn(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("t1_writeadd_m", 32'(writeadd_m), 32'd1);
    chk("t1_writeadd_x2", 32'(writeadd_x), 32'd2);
    setIn(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("t1_writeadd_w", 32'(writeadd_w), 32'd1);
    idle();
    repeat (3) tick();
    chk("t1_writeadd_w4", 32'(writeadd_w), 32'd4);
    tick();
    chk("t1_drained", 32'({valid_w, retire}), 32'd0);

    // Load in X while the next instruction stalls in D.
    expQ.push_back({5'd5, 1'b1});
    expQ.push_back({5'd8, 1'b1});
    expQ.push_back({5'd9, 1'b1});
    setIn(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    setIn(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("t2_load_x", 32'({load_x, writeadd_x}), 32'({1'b1, 5'd5}));
    setIn(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t2_stall_en", 32'({pc_en, fd_en}), 32'd0);
    tick();
    chk("t2_bubble", 32'({valid_d, valid_x, writeadd_x}), 32'({1'b1, 1'b0, 5'd0}));
    chk("t2_load_m", 32'({load_m, writeadd_m}), 32'({1'b1, 5'd5}));
    setIn(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t2_resume_en", 32'({pc_en, fd_en}), 32'd3);
    tick();
    chk("t2_held_to_x", 32'({writeadd_x, valid_m}), 32'({5'd8, 1'b0}));
    idle();
    repeat (4) tick();

    // Flush: branch (rd=0, no write) in X survives, rd=6 in D and rd=7 fetched die.
    expQ.push_back({5'd0, 1'b0});
    setIn(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setIn(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    setIn(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t3_flush_en", 32'({pc_en, fd_en}), 32'd3);
    tick();
    chk("t3_squash", 32'({valid_d, valid_x, valid_m, writeadd_x}), 32'({1'b0, 1'b0, 1'b1, 5'd0}));
    idle();
    repeat (4) tick();

    // Stall and flush together behave as flush.
    setIn(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    setIn(1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("t4_pc_en", 32'(pc_en), 32'd1);
    tick();
    chk("t4_squash", 32'({valid_d, valid_x}), 32'd0);
`ifdef PIPE_STATS_EN
    chk("t4_stall_cnt", 32'(stall_cnt), 32'(sat(expStall)));
    chk("t4_flush_cnt", 32'(flush_cnt), 32'(sat(expFlush)));
`endif
    idle();
    repeat (4) tick();

    // rd=0 with regwrite=1 never exports a write but still retires.
    expQ.push_back({5'd0, 1'b0});
    setIn(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    idle();
    tick();
    chk("t5_regwrite_x", 32'({valid_x, regwrite_x}), 32'({1'b1, 1'b0}));
    tick();
    chk("t5_regwrite_m", 32'({valid_m, regwrite_m}), 32'({1'b1, 1'b0}));
    tick();
    chk("t5_regwrite_w", 32'({retire, regwrite_w}), 32'({1'b1, 1'b0}));
    tick();
`ifdef PIPE_STATS_EN
    chk("t5_retire_cnt", 32'(retire_cnt), 32'(sat(retired)));
`endif

    // Asynchronous reset with every stage occupied.
    for (int i = 13; i <= 16; i++) begin
      setIn(1'b1, 5'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("t6_all_valid", 32'({valid_d, valid_x, valid_m, valid_w}), 32'hF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_writeadd", 32'({writeadd_x, writeadd_m, writeadd_w}), 32'd0);
    chk("t6_rst_flags", 32'({regwrite_x, regwrite_m, regwrite_w, load_x, load_m, retire}), 32'd0);
    chk("t6_rst_valid", 32'({valid_d, valid_x, valid_m, valid_w}), 32'd0);
    chk("t6_rst_pc_en", 32'({pc_en, fd_en}), 32'd3);
`ifdef PIPE_STATS_EN
    chk("t6_rst_cnts", 32'({stall_cnt, flush_cnt, retire_cnt}), 32'd0);
`endif
    expQ.delete();
    expStall = 0;
    expFlush = 0;
    retired  = 0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

`ifdef PIPE_STATS_EN
    setIn(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    idle();
    tick();
`endif

    chk("queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
